// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: program-load stream into the fetch controller.
//   load_valid  producer offers a program word
//   load_data   32-bit program word, written to IMEM unchanged
//   load_last   final word of the program, qualified by load_valid
//   load_ready  controller accepts a word this cycle
// Modports: master = program source, slave = fetch_ctrl.
interface fetch_ctrl_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// After reset it streams a program into IMEM through the load interface, then runs the fetch
// PC, folding halt, branch redirect and stall into a single PC update per cycle.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   load                 fetch_ctrl_if.slave program-load stream (valid/ready)
//   imem_we/waddr/wdata  IMEM write port, live only while loading
//   stall                hold PC (level)
//   do_branch/branch_addr redirect PC (target forced word aligned)
//   halt_req             stop fetching until reset
//   pc, pc4              registered fetch PC and its combinational successor
//   fetch_valid          instruction at pc is valid for decode this cycle
//   state                00 LOAD, 01 RUN, 10 STALL, 11 HALT
//   fetch_count, stall_count  performance counters, present only with FETCH_CTRL_PERF_EN
//
// Build option: define FETCH_CTRL_PERF_EN to add the two 32-bit performance counters.
module fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  fetch_ctrl_if.slave       load,
  output logic              imem_we,
  output logic [AW-1:0]     imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              stall,
  input  logic              do_branch,
  input  logic [31:0]       branch_addr,
  input  logic              halt_req,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              fetch_valid,
  output logic [1:0]        state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    StLoad  = 2'b00,
    StRun   = 2'b01,
    StStall = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [AW-1:0]   count_q;
  logic            fetch_valid_q;
  logic            load_ready_q;

  logic            accept;
  logic            last_slot;
  logic [31:0]     branch_tgt;

  assign accept     = load.load_valid & load_ready_q;
  assign last_slot  = (count_q == AW'(IMEM_DEPTH - 1));
  assign branch_tgt = {branch_addr[31:2], 2'b00};

  // IMEM write port is a pure function of the current handshake.
  assign imem_we    = accept;
  assign imem_waddr = count_q;
  assign imem_wdata = load.load_data;

  assign load.load_ready = load_ready_q;
  assign pc              = pc_q;
  assign pc4             = pc_q + 32'd4;
  assign fetch_valid     = fetch_valid_q;
  assign state           = state_q;

  // Single-process FSM; fetch_valid and load_ready are registered alongside the state so they
  // always agree with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StLoad;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      fetch_valid_q <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            count_q <= count_q + AW'(1);
            // A full IMEM ends the load even without load_last.
            if (load.load_last || last_slot) begin
              state_q       <= StRun;
              fetch_valid_q <= 1'b1;
              load_ready_q  <= 1'b0;
            end
          end
        end
        StRun, StStall: begin
          if (halt_req) begin
            state_q       <= StHalt;
            fetch_valid_q <= 1'b0;
          end else if (do_branch) begin
            pc_q <= branch_tgt;
            if (stall) begin
              state_q       <= StStall;
              fetch_valid_q <= 1'b0;
            end else begin
              state_q       <= StRun;
              fetch_valid_q <= 1'b1;
            end
          end else if (stall) begin
            state_q       <= StStall;
            fetch_valid_q <= 1'b0;
          end else begin
            // Leaving STALL re-presents the held instruction once before advancing.
            if (state_q == StRun) begin
              pc_q <= pc_q + 32'd4;
            end
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
          end
        end
        StHalt: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (fetch_valid_q) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (state_q == StStall) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
